// File: rtl/aes_host_sequencer.sv
// aes_host_sequencer: loads key/plaintext into aes_core over the word-serial register bus, starts it, reads back the result.
// Latency: accept at T -> writes T+2..T+10 (core idle) -> out_valid at U -> reads U+1..U+4 -> rsp_valid from U+6.
// Backpressure: cmd_ready_o only in IDLE; the response is held stable until rsp_ready_i; watchdog aborts stalled waits.
module aes_host_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [127:0] cmd_key_i,
  input  logic [127:0] cmd_pt_i,
  output logic         reg_we_o,
  output logic         reg_re_o,
  output logic [3:0]   reg_addr_o,
  output logic [31:0]  reg_wdata_o,
  input  logic [31:0]  reg_rdata_i,
  input  logic         core_idle_i,
  input  logic         core_out_valid_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_data_o,
  output logic         rsp_timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WR,
    S_WAIT_OUT,
    S_RD,
    S_RESP
  } state_t;

  state_t state, state_n;

  // Watchdog for the two wait states; step sequences the write and read bursts.
  logic [CNT_W-1:0] wdog;
  logic [3:0]       step;

  // Word 0 lives in the top 32 bits, so word i is element 3-i of each array.
  logic [3:0][31:0] key_q, pt_q, cap_q;
  logic             to_q;

  logic       accept, expire, wdog_max, to_set;
  logic [1:0] rd_sel;

  assign accept   = (state == S_IDLE) && cmd_valid_i;
  assign expire   = (wdog == CNT_W'(TIMEOUT_CYCLES - 1));
  assign wdog_max = &wdog;
  // Read data arrives one cycle after its strobe, so capture step k holds word k-1.
  assign rd_sel   = step[1:0] - 2'd1;

  // Next state and bus/handshake outputs, all decoded from the current state.
  always_comb begin
    state_n     = state;
    cmd_ready_o = 1'b0;
    reg_we_o    = 1'b0;
    reg_re_o    = 1'b0;
    reg_addr_o  = 4'd0;
    reg_wdata_o = 32'd0;
    rsp_valid_o = 1'b0;
    to_set      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_n = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (core_idle_i) begin
          state_n = S_WR;
        end else if (expire) begin
          state_n = S_RESP;
          to_set  = 1'b1;
        end
      end
      S_WR: begin
        reg_we_o   = 1'b1;
        reg_addr_o = step;
        if (step < 4'd4)      reg_wdata_o = key_q[~step[1:0]];
        else if (step < 4'd8) reg_wdata_o = pt_q[~step[1:0]];
        else                  reg_wdata_o = 32'h1;
        if (step == 4'd8) state_n = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        // A valid seen on the expiry cycle still wins over the abort.
        if (core_out_valid_i) begin
          state_n = S_RD;
        end else if (expire) begin
          state_n = S_RESP;
          to_set  = 1'b1;
        end
      end
      S_RD: begin
        if (step < 4'd4) begin
          reg_re_o   = 1'b1;
          reg_addr_o = 4'd9 + step;
        end
        if (step == 4'd4) state_n = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  // Watchdog and burst step restart on every state change; the watchdog saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog <= '0;
      step <= 4'd0;
    end else if (state_n != state) begin
      wdog <= '0;
      step <= 4'd0;
    end else begin
      if ((state == S_WAIT_IDLE || state == S_WAIT_OUT) && !wdog_max) wdog <= wdog + 1'b1;
      if (state == S_WR || state == S_RD) step <= step + 4'd1;
    end
  end

  // Command payload, read-back capture and timeout flag; capture clears on accept so an abort returns zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= '0;
      pt_q  <= '0;
      cap_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (accept) begin
        key_q <= cmd_key_i;
        pt_q  <= cmd_pt_i;
        cap_q <= '0;
        to_q  <= 1'b0;
      end else if (to_set) begin
        to_q  <= 1'b1;
      end
      if (state == S_RD && step != 4'd0) cap_q[~rd_sel] <= reg_rdata_i;
    end
  end

  assign rsp_data_o    = cap_q;
  assign rsp_timeout_o = to_q;

endmodule

// File: tb/tb_aes_host_sequencer.sv
`timescale 1ns/1ps
// Randomized bench: a transaction-level timeline model predicts every output on every cycle.
module tb_aes_host_sequencer;
  localparam int TO = 64;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [127:0] cmd_key_i = '0;
  logic [127:0] cmd_pt_i = '0;
  logic         reg_we_o, reg_re_o;
  logic [3:0]   reg_addr_o;
  logic [31:0]  reg_wdata_o;
  logic [31:0]  reg_rdata_i = '0;
  logic         core_idle_i = 1'b0;
  logic         core_out_valid_i = 1'b0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [127:0] rsp_data_o;
  logic         rsp_timeout_o;

  aes_host_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_key_i(cmd_key_i), .cmd_pt_i(cmd_pt_i),
    .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
    .core_idle_i(core_idle_i), .core_out_valid_i(core_out_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0, n_print = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      if (n_print < 40) $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp_v);
      n_print++;
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      if (n_print < 40) $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp_v);
      n_print++;
    end
  endtask

  function automatic logic [31:0] wd(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  // Transaction plan: the cycle of every bus event, derived from accept time and the chosen core delays.
  bit           pv = 1'b0;
  int           p_T = -1, p_di, p_do, p_w0, p_S, p_U, p_R, p_H = -2;
  bit           p_hasw, p_hasr, p_to;
  logic [127:0] p_key, p_pt, p_ct;

  // Observations of the DUT for per-transaction literal checks.
  int           wl_cyc[$];
  logic [3:0]   wl_addr[$];
  logic [31:0]  wl_dat[$];
  int           rd_cnt, hs_cnt, hs_cyc, acc_cyc;
  logic [127:0] hs_dat;
  logic         hs_to;
  logic         last_re = 1'b0;
  logic [3:0]   last_addr = 4'd0;

  int         c, k;
  logic       e_rdy, e_we, e_re, e_rv;
  logic [3:0] e_addr;
  logic [31:0] e_wd;

  // Per-cycle compare against the plan, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        c      = cyc;
        e_rdy  = !pv || c <= p_T || c > p_H;
        e_we   = pv && p_hasw && c >= p_w0 && c <= p_w0 + 8;
        e_re   = pv && p_hasr && c >= p_U + 1 && c <= p_U + 4;
        e_rv   = pv && c >= p_R && c <= p_H;
        e_addr = 4'd0;
        e_wd   = 32'd0;
        if (e_we) begin
          k = c - p_w0;
          e_addr = 4'(k);
          e_wd = (k < 4) ? wd(p_key, k) : ((k < 8) ? wd(p_pt, k - 4) : 32'h1);
        end else if (e_re) begin
          e_addr = 4'(9 + c - p_U - 1);
        end
        chk("cmd_ready", 128'(cmd_ready_o), 128'(e_rdy));
        chk("reg_we", 128'(reg_we_o), 128'(e_we));
        chk("reg_re", 128'(reg_re_o), 128'(e_re));
        chk("reg_addr", 128'(reg_addr_o), 128'(e_addr));
        chk("reg_wdata", 128'(reg_wdata_o), 128'(e_wd));
        chk("rsp_valid", 128'(rsp_valid_o), 128'(e_rv));
        if (e_rv) begin
          chk("rsp_data", rsp_data_o, p_to ? 128'd0 : p_ct);
          chk("rsp_timeout", 128'(rsp_timeout_o), 128'(p_to));
        end
        if (reg_we_o) begin
          wl_cyc.push_back(c);
          wl_addr.push_back(reg_addr_o);
          wl_dat.push_back(reg_wdata_o);
        end
        if (reg_re_o) rd_cnt++;
        if (rsp_valid_o && rsp_ready_i) begin
          hs_cnt++;
          hs_cyc = c;
          hs_dat = rsp_data_o;
          hs_to  = rsp_timeout_o;
        end
        if (cmd_valid_i && cmd_ready_o) acc_cyc = c;
      end
      last_re   = reg_re_o;
      last_addr = reg_addr_o;
    end
  end

  // Environment: core status, register read data and response ready, with noise wherever the DUT must ignore them.
  task automatic drive_env();
    if (pv && cyc > p_T) core_idle_i = (cyc >= p_T + 1 + p_di);
    else                 core_idle_i = 1'($urandom_range(0, 1));
    if (pv && p_hasw && cyc > p_S) core_out_valid_i = (cyc >= p_S + 1 + p_do);
    else                           core_out_valid_i = 1'($urandom_range(0, 1));
    if (pv && cyc >= p_R && cyc <= p_H) rsp_ready_i = (cyc == p_H);
    else                                rsp_ready_i = 1'($urandom_range(0, 1));
    if (last_re && last_addr >= 4'd9 && last_addr <= 4'd12) reg_rdata_i = wd(p_ct, int'(last_addr) - 9);
    else                                                    reg_rdata_i = $urandom;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    drive_env();
  endtask

  task automatic run_txn(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                         input int di, input int dout, input int rdl, input bit rst_mid, input bit hold);
    cmd_key_i   = key;
    cmd_pt_i    = pt;
    cmd_valid_i = 1'b1;
    while (pv && cyc <= p_H) step();
    wl_cyc.delete(); wl_addr.delete(); wl_dat.delete();
    rd_cnt = 0; hs_cnt = 0;
    p_T = cyc; p_di = di; p_do = dout;
    p_key = key; p_pt = pt; p_ct = ct;
    p_hasw = (di <= TO - 1);
    p_w0   = p_T + 2 + di;
    p_S    = p_w0 + 8;
    p_hasr = p_hasw && (dout <= TO - 1);
    p_U    = p_S + 1 + dout;
    p_R    = !p_hasw ? p_T + 1 + TO : (!p_hasr ? p_S + 1 + TO : p_U + 6);
    p_to   = !p_hasr;
    p_H    = p_R + rdl;
    pv     = 1'b1;
    while (cyc <= p_H) begin
      step();
      cmd_valid_i = hold ? 1'b1 : 1'($urandom_range(0, 1));
      cmd_key_i   = {$urandom, $urandom, $urandom, $urandom};
      cmd_pt_i    = {$urandom, $urandom, $urandom, $urandom};
      if (rst_mid && cyc == p_w0 + 5) begin
        chk("pre_rst_we", 128'(reg_we_o), 128'd1);
        chk("pre_rst_addr", 128'(reg_addr_o), 128'd5);
        #1 rst_ni = 1'b0;
        cmd_valid_i = 1'b0;
        #1;
        chk("rst_async_we", 128'(reg_we_o), 128'd0);
        chk("rst_async_re", 128'(reg_re_o), 128'd0);
        chk("rst_async_addr", 128'(reg_addr_o), 128'd0);
        chk("rst_async_wdata", 128'(reg_wdata_o), 128'd0);
        chk("rst_async_ready", 128'(cmd_ready_o), 128'd1);
        chk("rst_async_rsp_valid", 128'(rsp_valid_o), 128'd0);
        pv = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        drive_env();
        return;
      end
    end
  endtask

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [31:0] fw [9] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                          32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 32'h00000001};

  logic [127:0] rk, rp, rc;
  int bp_hs, di, dout;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_cmd_ready", 128'(cmd_ready_o), 128'd1);
    chk("reset_we", 128'(reg_we_o), 128'd0);
    chk("reset_re", 128'(reg_re_o), 128'd0);
    chk("reset_addr", 128'(reg_addr_o), 128'd0);
    chk("reset_wdata", 128'(reg_wdata_o), 128'd0);
    chk("reset_rsp_valid", 128'(rsp_valid_o), 128'd0);
    chk("reset_rsp_data", rsp_data_o, 128'd0);
    chk("reset_rsp_timeout", 128'(rsp_timeout_o), 128'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    drive_env();

    // FIPS-197 vector, core idle immediately, result 12 cycles after the start write.
    run_txn(FK, FP, FC, 0, 11, 0, 1'b0, 1'b0);
    chki("fips_nwr", wl_cyc.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < wl_cyc.size()) begin
        chki("fips_wr_addr", int'(wl_addr[i]), i);
        chk("fips_wr_data", 128'(wl_dat[i]), 128'(fw[i]));
        chki("fips_wr_consecutive", wl_cyc[i] - wl_cyc[0], i);
      end
    end
    chk("fips_ct", hs_dat, FC);
    chk("fips_timeout", 128'(hs_to), 128'd0);
    chki("fips_nrd", rd_cnt, 4);

    // Busy core for 50 cycles: first write one cycle after idle rises.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rc = {$urandom, $urandom, $urandom, $urandom};
    run_txn(rk, ~rk, rc, 50, 5, 1, 1'b0, 1'b0);
    chki("busy_nwr", wl_cyc.size(), 9);
    if (wl_cyc.size() > 0) chki("busy_first_wr_gap", wl_cyc[0] - (p_T + 1 + 50), 1);
    chk("busy_ct", hs_dat, rc);

    // Core never idle: abort with no writes.
    run_txn(rk, rk, rc, 1000, 0, 2, 1'b0, 1'b0);
    chki("idle_to_nwr", wl_cyc.size(), 0);
    chki("idle_to_nrsp", hs_cnt, 1);
    chk("idle_to_flag", 128'(hs_to), 128'd1);
    chk("idle_to_data", hs_dat, 128'd0);

    // Output never valid: abort after the writes, no reads.
    run_txn(FK, FP, FC, 0, 1000, 0, 1'b0, 1'b0);
    chki("out_to_nwr", wl_cyc.size(), 9);
    chki("out_to_nrd", rd_cnt, 0);
    chk("out_to_flag", 128'(hs_to), 128'd1);
    chk("out_to_data", hs_dat, 128'd0);

    // Output valid on the expiry cycle counts as success.
    run_txn(rk, ~rk, rc, 1, TO - 1, 0, 1'b0, 1'b0);
    chki("expiry_nrd", rd_cnt, 4);
    chk("expiry_flag", 128'(hs_to), 128'd0);
    chk("expiry_ct", hs_dat, rc);

    // Response backpressure for 20 cycles with a new command held pending.
    run_txn(FK, FP, FC, 0, 3, 20, 1'b0, 1'b1);
    bp_hs = hs_cyc;
    chk("bp_ct", hs_dat, FC);
    run_txn(rk, rk, rc, 0, 2, 0, 1'b0, 1'b0);
    chki("bp_next_accept_gap", acc_cyc - bp_hs, 1);
    chk("bp_next_ct", hs_dat, rc);

    // Reset during the addr-5 write, then a clean restart.
    run_txn(FK, FP, FC, 0, 5, 0, 1'b1, 1'b0);
    run_txn(FK, FP, FC, 0, 7, 0, 1'b0, 1'b0);
    chki("post_rst_nwr", wl_cyc.size(), 9);
    if (wl_cyc.size() > 0) chki("post_rst_first_addr", int'(wl_addr[0]), 0);
    chk("post_rst_ct", hs_dat, FC);

    // Random traffic, including boundary delays either side of the watchdog limit.
    for (int n = 0; n < 25; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       di = TO;
        1:       di = TO - 1;
        default: di = $urandom_range(0, 6);
      endcase
      case ($urandom_range(0, 9))
        0:       dout = TO + $urandom_range(0, 3);
        1:       dout = TO - 1;
        default: dout = $urandom_range(0, 20);
      endcase
      run_txn(rk, rp, rc, di, dout, $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)));
    end

    cmd_valid_i = 1'b0;
    while (pv && cyc <= p_H) step();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, limit 200000", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
